// File: rtl/barrier_ctrl_pkg.sv
// Shared types and default constants for the barrier handshake controller.
package barrier_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPEN    = 2'd1,
    ST_REQ     = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam int DEFAULT_SETTLE_CYCLES  = 2;
  localparam int DEFAULT_SYNC_STAGES    = 2;
  localparam int DEFAULT_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/barrier_handshake_controller_sync_bit.sv
// Single-bit synchronizer: a STAGES-deep flop chain with synchronous reset.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/barrier_handshake_controller.sv
// Sequences a double-latching barrier: hold word, open enable, four-phase req/ack.
// Optional handshake timeout with sticky err: define BARRIER_CTRL_TIMEOUT_EN.
module barrier_handshake_controller
  import barrier_ctrl_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int SETTLE_CYCLES  = DEFAULT_SETTLE_CYCLES,
  parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic [WIDTH-1:0] src_data,
  output logic [WIDTH-1:0] barrier_in,
  output logic             barrier_enable,
  output logic             dst_req,
  input  logic             dst_ack,
  output logic             err,
  output state_t           state
);

  // Source port: a word transfers on any edge where src_valid && src_ready;
  // src_valid may be held indefinitely, src_ready is high only in IDLE.

  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  logic [CW-1:0] settle_cnt;
  logic          ack_sync;
  logic          timeout_hit;

  sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (dst_ack),
    .q   (ack_sync)
  );

  assign src_ready = (state == ST_IDLE);

`ifdef BARRIER_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;
  logic          err_q;

  assign timeout_hit = ((state == ST_REQ) || (state == ST_RELEASE)) &&
                       (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign err = err_q;

  // Counter is zero on entry to REQ and to RELEASE.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (timeout_hit) err_q <= 1'b1;
      if ((state == ST_IDLE) || (state == ST_OPEN) || timeout_hit ||
          ((state == ST_REQ) && ack_sync))
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      barrier_in     <= '0;
      barrier_enable <= 1'b0;
      dst_req        <= 1'b0;
      settle_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (src_valid) begin
            barrier_in     <= src_data;
            settle_cnt     <= CW'(SETTLE_CYCLES - 1);
            barrier_enable <= 1'b1;
            state          <= ST_OPEN;
          end
        end
        ST_OPEN: begin
          // Enable drops on the same edge req rises, so they never overlap.
          if (settle_cnt == '0) begin
            barrier_enable <= 1'b0;
            dst_req        <= 1'b1;
            state          <= ST_REQ;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        ST_REQ: begin
          if (ack_sync) begin
            dst_req <= 1'b0;
            state   <= ST_RELEASE;
          end else if (timeout_hit) begin
            dst_req <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        ST_RELEASE: begin
          if (!ack_sync || timeout_hit) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_barrier_handshake_controller.sv
// Self-checking bench for barrier_handshake_controller (scoreboarded held words).
module tb_barrier_handshake_controller;
  import barrier_ctrl_pkg::*;

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int SY = 2;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         src_valid = 1'b0;
  logic         src_ready;
  logic [W-1:0] src_data = '0;
  logic [W-1:0] barrier_in;
  logic         barrier_enable;
  logic         dst_req;
  logic         dst_ack = 1'b0;
  logic         err;
  state_t       state;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  barrier_handshake_controller #(
    .WIDTH(W), .SETTLE_CYCLES(S), .SYNC_STAGES(SY), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_ready(src_ready),
    .src_data(src_data), .barrier_in(barrier_in), .barrier_enable(barrier_enable),
    .dst_req(dst_req), .dst_ack(dst_ack), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one word; returns sampled just after the accepting edge.
  task automatic send_word(input logic [W-1:0] d);
    n_cmp++;
    if (src_ready !== 1'b1) begin
      n_err++;
      $display("FAIL send_ready: src_ready=%b required 1", src_ready);
    end
    src_valid = 1'b1;
    src_data  = d;
    exp_q.push_back(d);
    tick();
  endtask

  // From the sample after acceptance through return to IDLE.
  task automatic run_handshake(input int ack_delay);
    int k;
    int en_cnt;
    int req_k;
    logic [W-1:0] exp;
    k = 0; en_cnt = 0; req_k = -1; exp = '0;
    while (req_k < 0 && k < 20) begin
      k++;
      if (barrier_enable) en_cnt++;
      n_cmp++;
      if (barrier_enable && dst_req) begin
        n_err++;
        $display("FAIL overlap: enable=%b req=%b at sample %0d", barrier_enable, dst_req, k);
      end
      n_cmp++;
      if (src_ready !== 1'b0) begin
        n_err++;
        $display("FAIL busy_ready: src_ready=%b required 0", src_ready);
      end
      if (dst_req === 1'b1) req_k = k;
      else tick();
    end
    n_cmp++;
    if (en_cnt != S) begin
      n_err++;
      $display("FAIL enable_len: %0d cycles required %0d", en_cnt, S);
    end
    n_cmp++;
    if (req_k != S + 1) begin
      n_err++;
      $display("FAIL req_latency: rose at %0d required %0d", req_k, S + 1);
    end
    if (exp_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard_empty: size=0 required 1");
    end else begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (barrier_in !== exp) begin
        n_err++;
        $display("FAIL held_word: barrier_in=%h required %h", barrier_in, exp);
      end
    end
    repeat (ack_delay) tick();
    dst_ack = 1'b1;
    repeat (SY) tick();
    n_cmp++;
    if (dst_req !== 1'b1 || state !== ST_REQ) begin
      n_err++;
      $display("FAIL req_hold: req=%b state=%0d required 1/%0d", dst_req, state, ST_REQ);
    end
    tick();
    n_cmp++;
    if (dst_req !== 1'b0 || state !== ST_RELEASE || barrier_in !== exp) begin
      n_err++;
      $display("FAIL release: req=%b state=%0d in=%h required 0/%0d/%h",
               dst_req, state, barrier_in, ST_RELEASE, exp);
    end
    dst_ack = 1'b0;
    repeat (SY) tick();
    n_cmp++;
    if (src_ready !== 1'b0 || barrier_in !== exp) begin
      n_err++;
      $display("FAIL release_hold: ready=%b in=%h required 0/%h", src_ready, barrier_in, exp);
    end
    tick();
    n_cmp++;
    if (src_ready !== 1'b1 || state !== ST_IDLE || barrier_in !== exp) begin
      n_err++;
      $display("FAIL back_idle: ready=%b state=%0d in=%h required 1/%0d/%h",
               src_ready, state, barrier_in, ST_IDLE, exp);
    end
    k = 0;
    while (src_ready !== 1'b1 && k < 20) begin
      k++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (src_ready !== 1'b1 || barrier_enable !== 1'b0 || dst_req !== 1'b0 ||
        barrier_in !== '0 || err !== 1'b0 || state !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset_vals: ready=%b en=%b req=%b in=%h err=%b state=%0d required 1/0/0/00/0/0",
               src_ready, barrier_enable, dst_req, barrier_in, err, state);
    end
    dst_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (state !== ST_IDLE || dst_req !== 1'b0 || barrier_enable !== 1'b0) begin
        n_err++;
        $display("FAIL idle_ack: state=%0d req=%b en=%b required 0/0/0", state, dst_req, barrier_enable);
      end
    end
    dst_ack = 1'b0;
    repeat (SY + 2) tick();
  endtask

  task automatic test_single();
    send_word(8'hA5);
    src_valid = 1'b0;
    run_handshake(3);
  endtask

  task automatic test_back_to_back();
    send_word(8'h01);
    src_data = 8'h02;
    run_handshake(2);
    exp_q.push_back(8'h02);
    tick();
    src_valid = 1'b0;
    n_cmp++;
    if (barrier_in !== 8'h02 || state !== ST_OPEN) begin
      n_err++;
      $display("FAIL second_accept: in=%h state=%0d required 02/%0d", barrier_in, state, ST_OPEN);
    end
    run_handshake(1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 5; i++) begin
      send_word(W'($urandom_range(0, 255)));
      src_valid = 1'b0;
      src_data  = W'($urandom_range(0, 255));
      run_handshake($urandom_range(1, 6));
    end
  endtask

  task automatic wait_req(input string tag);
    int k;
    k = 0;
    while (dst_req !== 1'b1 && k < 20) begin
      k++;
      tick();
    end
    n_cmp++;
    if (dst_req !== 1'b1) begin
      n_err++;
      $display("FAIL %s_req_timeout: req=%b required 1", tag, dst_req);
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      if (barrier_in !== exp_q[0]) begin
        n_err++;
        $display("FAIL %s_held: in=%h required %h", tag, barrier_in, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_reset_mid();
    send_word(8'h3C);
    src_valid = 1'b0;
    wait_req("mid");
    rst = 1'b1;
    tick();
    n_cmp++;
    if (dst_req !== 1'b0 || barrier_enable !== 1'b0 || barrier_in !== '0 ||
        state !== ST_IDLE || src_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid: req=%b en=%b in=%h state=%0d ready=%b required 0/0/00/0/1",
               dst_req, barrier_enable, barrier_in, state, src_ready);
    end
    rst = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (state !== ST_IDLE || dst_req !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_stay: state=%0d req=%b required 0/0", state, dst_req);
    end
  endtask

  task automatic test_timeout();
    int n;
    send_word(8'h5A);
    src_valid = 1'b0;
    wait_req("tmo");
    n = 0;
`ifdef BARRIER_CTRL_TIMEOUT_EN
    while (dst_req === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    n_cmp++;
    if (n != TO || err !== 1'b1 || src_ready !== 1'b1 || state !== ST_IDLE) begin
      n_err++;
      $display("FAIL timeout: req_cycles=%0d err=%b ready=%b state=%0d required %0d/1/1/0",
               n, err, src_ready, state, TO);
    end
    repeat (5) tick();
    n_cmp++;
    if (err !== 1'b1) begin
      n_err++;
      $display("FAIL err_sticky: err=%b required 1", err);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL err_clear: err=%b required 0", err);
    end
`else
    repeat (1000) begin
      tick();
      n++;
      n_cmp++;
      if (dst_req !== 1'b1 || err !== 1'b0) begin
        n_err++;
        $display("FAIL no_timeout: cycle=%0d req=%b err=%b required 1/0", n, dst_req, err);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (state !== ST_IDLE || dst_req !== 1'b0) begin
      n_err++;
      $display("FAIL recover: state=%0d req=%b required 0/0", state, dst_req);
    end
`endif
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
